// File: rtl/apb_gpio_ext.sv
// Parametrised APB GPIO: direction, atomic set/clear, per-pin IRQ type, W1C status.
// Optional per-pin input debounce filter enabled by APB_GPIO_DEBOUNCE_EN.
module apb_gpio_ext #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_GPIO       = 32,
  parameter int DB_CNT_WIDTH   = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_GPIO-1:0]       gpio_in,
  output logic [NUM_GPIO-1:0]       gpio_out,
  output logic [NUM_GPIO-1:0]       gpio_dir,
  output logic                      interrupt
);

  localparam logic [3:0] A_DIR = 4'd0;
  localparam logic [3:0] A_IN  = 4'd1;
  localparam logic [3:0] A_OUT = 4'd2;
  localparam logic [3:0] A_SET = 4'd3;
  localparam logic [3:0] A_CLR = 4'd4;
  localparam logic [3:0] A_IEN = 4'd5;
  localparam logic [3:0] A_T0  = 4'd6;
  localparam logic [3:0] A_T1  = 4'd7;
  localparam logic [3:0] A_ST  = 4'd8;
  localparam logic [3:0] A_DB  = 4'd9;

  logic [3:0]          ofs;
  logic                access;
  logic                wr;
  logic                mapped;
  logic [31:0]         rdata;
  logic [NUM_GPIO-1:0] wdata;
  logic [NUM_GPIO-1:0] w1c;
  logic                unused_ok;

  logic [NUM_GPIO-1:0] r_dir, r_out, r_ien, r_t0, r_t1, r_st;
  logic [NUM_GPIO-1:0] sync0, sync1, filt, r_in, r_in_d;
  logic [NUM_GPIO-1:0] rise, fall, evt;

  assign ofs       = PADDR[5:2];
  assign access    = PSEL & PENABLE;
  assign wr        = access & PWRITE;
  assign wdata     = PWDATA[NUM_GPIO-1:0];
  assign w1c       = (wr && ofs == A_ST) ? wdata : '0;
  assign unused_ok = ^{PADDR, PWDATA};

`ifdef APB_GPIO_DEBOUNCE_EN
  localparam logic [DB_CNT_WIDTH-1:0] DB_ONE = 1;

  logic [DB_CNT_WIDTH-1:0] r_db;
  logic [DB_CNT_WIDTH-1:0] cnt [NUM_GPIO];
  logic [NUM_GPIO-1:0]     filt_q;
  logic                    bypass;
  logic                    db_wr;

  assign bypass = (r_db <= DB_ONE);
  assign db_wr  = wr && (ofs == A_DB);
  assign filt   = bypass ? sync1 : filt_q;

  // Change accepted only after r_db consecutive cycles of disagreement.
  always_ff @(posedge HCLK) begin
    for (int i = 0; i < NUM_GPIO; i++) begin
      if (HRESET) begin
        filt_q[i] <= 1'b0;
        cnt[i]    <= '0;
      end else if (bypass) begin
        filt_q[i] <= sync1[i];
        cnt[i]    <= '0;
      end else if (db_wr) begin
        cnt[i] <= '0;
      end else if (sync1[i] != filt_q[i]) begin
        if (cnt[i] == r_db - DB_ONE) begin
          filt_q[i] <= sync1[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_ONE;
        end
      end else begin
        cnt[i] <= '0;
      end
    end
  end
`else
  assign filt = sync1;
`endif

  assign rise = r_in & ~r_in_d;
  assign fall = ~r_in & r_in_d;
  assign evt  = (~r_t1 & ~r_t0 & r_in)
              | (~r_t1 &  r_t0 & ~r_in)
              | ( r_t1 & ~r_t0 & rise)
              | ( r_t1 &  r_t0 & fall);

  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    case (ofs)
      A_DIR:        rdata = 32'(r_dir);
      A_IN:         rdata = 32'(r_in);
      A_OUT:        rdata = 32'(r_out);
      A_SET, A_CLR: rdata = '0;
      A_IEN:        rdata = 32'(r_ien);
      A_T0:         rdata = 32'(r_t0);
      A_T1:         rdata = 32'(r_t1);
      A_ST:         rdata = 32'(r_st);
`ifdef APB_GPIO_DEBOUNCE_EN
      A_DB:         rdata = 32'(r_db);
`endif
      default:      mapped = 1'b0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_dir  <= '0;
      r_out  <= '0;
      r_ien  <= '0;
      r_t0   <= '0;
      r_t1   <= '0;
      r_st   <= '0;
      sync0  <= '0;
      sync1  <= '0;
      r_in   <= '0;
      r_in_d <= '0;
`ifdef APB_GPIO_DEBOUNCE_EN
      r_db   <= '0;
`endif
    end else begin
      sync0  <= gpio_in;
      sync1  <= sync0;
      r_in   <= filt;
      r_in_d <= r_in;
      // A fresh event wins over a W1C in the same cycle.
      r_st   <= (r_st & ~w1c) | (r_ien & evt);
      if (wr) begin
        case (ofs)
          A_DIR:   r_dir <= wdata;
          A_OUT:   r_out <= wdata;
          A_SET:   r_out <= r_out | wdata;
          A_CLR:   r_out <= r_out & ~wdata;
          A_IEN:   r_ien <= wdata;
          A_T0:    r_t0  <= wdata;
          A_T1:    r_t1  <= wdata;
`ifdef APB_GPIO_DEBOUNCE_EN
          A_DB:    r_db  <= PWDATA[DB_CNT_WIDTH-1:0];
`endif
          default: ;
        endcase
      end
    end
  end

  assign PRDATA    = rdata;
  assign PREADY    = 1'b1;
  assign PSLVERR   = access & ~mapped;
  assign gpio_out  = r_out;
  assign gpio_dir  = r_dir;
  assign interrupt = |r_st;

endmodule

// File: tb/tb_apb_gpio_ext.sv
// Directed self-checking bench for apb_gpio_ext (8 pins).
// Debounce scenario runs only when APB_GPIO_DEBOUNCE_EN is defined.
module tb_apb_gpio_ext;

  logic        clk;
  logic        rst;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_dir;
  logic        irq;

  int n_chk;
  int n_fail;

  apb_gpio_ext #(
    .APB_ADDR_WIDTH(12),
    .NUM_GPIO(8),
    .DB_CNT_WIDTH(8)
  ) dut (
    .HCLK(clk),
    .HRESET(rst),
    .PADDR(paddr),
    .PWDATA(pwdata),
    .PWRITE(pwrite),
    .PSEL(psel),
    .PENABLE(penable),
    .PRDATA(prdata),
    .PREADY(pready),
    .PSLVERR(pslverr),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .gpio_dir(gpio_dir),
    .interrupt(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d,
                           output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    #1 err = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d,
                          output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1 d = prdata; err = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        e;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if (gpio_out !== 8'h00 || gpio_dir !== 8'h00 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: out=%h dir=%h irq=%b want 00 00 0",
               gpio_out, gpio_dir, irq);
    end
    n_chk++;
    if (pslverr !== 1'b0 || pready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_apb: pslverr=%b pready=%b want 0 1", pslverr, pready);
    end
    apb_write(12'h000, 32'hFF, e);
    apb_write(12'h008, 32'h3C, e);
    apb_write(12'h018, 32'h01, e);
    apb_write(12'h014, 32'h01, e);
    repeat (3) @(negedge clk);
    n_chk++;
    if (irq !== 1'b1 || gpio_dir !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_pre: irq=%b dir=%h want 1 ff", irq, gpio_dir);
    end
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008;
    pwdata = 32'hFFFF;
    @(negedge clk);
    penable = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #1;
    n_chk++;
    if (gpio_out !== 8'h00 || gpio_dir !== 8'h00 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: out=%h dir=%h irq=%b want 00 00 0",
               gpio_out, gpio_dir, irq);
    end
    for (int k = 0; k < 9; k++) begin
      apb_read(12'(k * 4), d, e);
      n_chk++;
      if (d !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h want 00000000", k, d);
      end
    end
  endtask

  task automatic test_output();
    logic [31:0] d;
    logic        e;
    gpio_in = 8'h5A;
    apb_write(12'h008, 32'h00F0, e);
    apb_write(12'h00C, 32'h0003, e);
    apb_write(12'h010, 32'h0010, e);
    n_chk++;
    if (gpio_out !== 8'hE3) begin
      n_fail++;
      $display("FAIL out_pins: got %h want e3", gpio_out);
    end
    apb_read(12'h008, d, e);
    n_chk++;
    if (d !== 32'hE3) begin
      n_fail++;
      $display("FAIL out_padout: got %h want 000000e3", d);
    end
    apb_read(12'h00C, d, e);
    n_chk++;
    if (d !== 32'h0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL out_set_rd: got %h err %b want 0 0", d, e);
    end
    apb_read(12'h004, d, e);
    n_chk++;
    if (d !== 32'h5A) begin
      n_fail++;
      $display("FAIL out_padin: got %h want 0000005a", d);
    end
  endtask

  task automatic test_rise_irq();
    logic [31:0] d;
    logic        e;
    apb_write(12'h01C, 32'h01, e);
    apb_write(12'h018, 32'h00, e);
    apb_write(12'h014, 32'h01, e);
    apb_read(12'h020, d, e);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL rise_idle: got %h want 0", d);
    end
    @(negedge clk);
    gpio_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_early: irq=%b want 0 after 3 edges", irq);
    end
    @(negedge clk);
    n_chk++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_edge4: irq=%b want 1 after 4 edges", irq);
    end
    apb_read(12'h020, d, e);
    n_chk++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL rise_status: got %h want 1", d);
    end
    apb_write(12'h020, 32'h1, e);
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_w1c: irq=%b want 0", irq);
    end
    gpio_in[0] = 1'b0;
    repeat (5) @(negedge clk);
    gpio_in[0] = 1'b1;
    @(negedge clk);
    apb_write(12'h020, 32'h1, e);
    apb_read(12'h020, d, e);
    n_chk++;
    if (d !== 32'h1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_w1c_race: status=%h irq=%b want 1 1", d, irq);
    end
    apb_write(12'h020, 32'h1, e);
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_clear2: irq=%b want 0", irq);
    end
  endtask

  task automatic test_level_low();
    logic [31:0] d;
    logic        e;
    gpio_in = 8'h52;
    apb_write(12'h01C, 32'h00, e);
    apb_write(12'h018, 32'h08, e);
    apb_write(12'h014, 32'h08, e);
    repeat (4) @(negedge clk);
    apb_read(12'h020, d, e);
    n_chk++;
    if (d !== 32'h08 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL lvl_set: status=%h irq=%b want 08 1", d, irq);
    end
    apb_write(12'h020, 32'h08, e);
    apb_read(12'h020, d, e);
    n_chk++;
    if (d !== 32'h08) begin
      n_fail++;
      $display("FAIL lvl_hold: status=%h want 08", d);
    end
    apb_write(12'h014, 32'h00, e);
    apb_read(12'h020, d, e);
    n_chk++;
    if (d !== 32'h08) begin
      n_fail++;
      $display("FAIL lvl_inten0: status=%h want 08", d);
    end
    apb_write(12'h014, 32'h08, e);
    gpio_in[3] = 1'b1;
    repeat (5) @(negedge clk);
    apb_write(12'h020, 32'h08, e);
    apb_read(12'h020, d, e);
    n_chk++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL lvl_clear: status=%h irq=%b want 0 0", d, irq);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic        e;
    apb_write(12'h000, 32'hFFFF_FFFF, e);
    apb_read(12'h000, d, e);
    n_chk++;
    if (d !== 32'h0000_00FF || e !== 1'b0) begin
      n_fail++;
      $display("FAIL map_dir_mask: got %h err %b want 000000ff 0", d, e);
    end
    apb_read(12'h030, d, e);
    n_chk++;
    if (d !== 32'h0 || e !== 1'b1) begin
      n_fail++;
      $display("FAIL map_rd30: got %h err %b want 0 1", d, e);
    end
    apb_write(12'h030, 32'h0, e);
    n_chk++;
    if (e !== 1'b1) begin
      n_fail++;
      $display("FAIL map_wr30_err: err=%b want 1", e);
    end
    apb_read(12'h000, d, e);
    n_chk++;
    if (d !== 32'hFF || gpio_out !== 8'hE3) begin
      n_fail++;
      $display("FAIL map_wr30_eff: dir=%h out=%h want ff e3", d, gpio_out);
    end
`ifndef APB_GPIO_DEBOUNCE_EN
    apb_read(12'h024, d, e);
    n_chk++;
    if (d !== 32'h0 || e !== 1'b1) begin
      n_fail++;
      $display("FAIL map_rd24: got %h err %b want 0 1", d, e);
    end
`endif
  endtask

`ifdef APB_GPIO_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] d;
    logic        e;
    logic        seen;
    apb_write(12'h024, 32'h4, e);
    apb_read(12'h024, d, e);
    n_chk++;
    if (d !== 32'h4 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL db_reg: got %h err %b want 4 0", d, e);
    end
    for (int len = 3; len <= 4; len++) begin
      seen = 1'b0;
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 12'h004;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (k == 0) gpio_in[2] = 1'b1;
        if (k == len) gpio_in[2] = 1'b0;
        #1 seen = seen | prdata[2];
      end
      psel = 1'b0; penable = 1'b0;
      n_chk++;
      if (seen !== (len == 4)) begin
        n_fail++;
        $display("FAIL db_pulse%0d: padin2 seen=%b want %b", len, seen,
                 len == 4);
      end
    end
  endtask
`endif

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    paddr   = '0;
    pwdata  = '0;
    pwrite  = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    gpio_in = '0;
    test_reset();
    test_output();
    test_rise_irq();
    test_level_low();
    test_unmapped();
`ifdef APB_GPIO_DEBOUNCE_EN
    test_debounce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
